// File: rtl/edge_counter_pkg.sv
// Shared types and helpers for the multi-channel edge detector / event counter.
package edge_counter_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_t;

    typedef enum logic {
        ST_WARMUP = 1'b0,
        ST_RUN    = 1'b1
    } fsm_t;

    // Readout index width, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic edge_match(input edge_mode_t mode, input logic cur,
                                        input logic prev);
        logic w_rise;
        logic w_fall;
        w_rise = cur & ~prev;
        w_fall = ~cur & prev;
        case (mode)
            EDGE_RISE: return w_rise;
            EDGE_FALL: return w_fall;
            EDGE_BOTH: return w_rise | w_fall;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/edge_counter_chan.sv
// One channel: input synchroniser, edge detector, event counter with overflow and
// threshold-hit flags.
module edge_counter_chan
    import edge_counter_pkg::*;
#(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_sig,
    input  logic             i_mask,
    input  edge_mode_t       i_mode,
    input  logic             i_run,
    input  logic             i_sat_en,
    input  logic [CNT_W-1:0] i_threshold,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_count,
    output logic             o_ovf,
    output logic             o_hit
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] w_sync_nxt;
    logic                   r_prev;
    logic                   w_sync;
    logic                   w_edge;
    logic [CNT_W-1:0]       r_count;
    logic [CNT_W-1:0]       w_count_nxt;
    logic                   r_ovf;
    logic                   w_ovf_nxt;
    logic                   r_hit;
    logic                   w_hit_nxt;

    if (SYNC_STAGES > 1) begin : g_shift
        assign w_sync_nxt = {r_sync[SYNC_STAGES-2:0], i_sig};
    end else begin : g_single
        assign w_sync_nxt = i_sig;
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    // The chain and prev track the input even when masked, so unmasking is glitch-free.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= w_sync_nxt;
            r_prev <= w_sync;
        end
    end

    assign w_edge = i_run & i_mask & edge_match(i_mode, w_sync, r_prev);

    always_comb begin
        w_count_nxt = r_count;
        w_ovf_nxt   = r_ovf;
        w_hit_nxt   = r_hit;
        if (i_clr) begin
            w_count_nxt = '0;
            w_ovf_nxt   = 1'b0;
            w_hit_nxt   = 1'b0;
        end else if (w_edge) begin
            if (r_count != CNT_MAX) begin
                w_count_nxt = r_count + 1'b1;
            end else begin
                w_ovf_nxt   = 1'b1;
                w_count_nxt = i_sat_en ? CNT_MAX : '0;
            end
            if ((i_threshold != '0) && (w_count_nxt == i_threshold)) begin
                w_hit_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_hit   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_ovf   <= w_ovf_nxt;
            r_hit   <= w_hit_nxt;
        end
    end

    assign o_count = r_count;
    assign o_ovf   = r_ovf;
    assign o_hit   = r_hit;

endmodule

// File: rtl/edge_counter_bank.sv
// Multi-channel edge counter bank: per-channel counters, a shared warm-up FSM that
// masks start-up edges, and a registered indexed readout.
module edge_counter_bank
    import edge_counter_pkg::*;
#(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [CHANNELS-1:0]           sig_in,
    input  logic [CHANNELS-1:0]           mask,
    input  logic [2*CHANNELS-1:0]         mode,
    input  logic                          sat_en,
    input  logic [CNT_W-1:0]              threshold,
    input  logic [CHANNELS-1:0]           clr,
    input  logic [idx_w(CHANNELS)-1:0]    rd_idx,
    output logic [CNT_W-1:0]              rd_count,
    output logic [CHANNELS-1:0]           ovf,
    output logic [CHANNELS-1:0]           hit,
    output logic                          ready
);

    localparam int unsigned          IDX_W     = idx_w(CHANNELS);
    localparam int unsigned          WARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [WARM_W-1:0]    WARM_LAST = WARM_W'(SYNC_STAGES);

    fsm_t              r_state;
    fsm_t              w_state_nxt;
    logic [WARM_W-1:0] r_warm_cnt;
    logic [WARM_W-1:0] w_warm_cnt_nxt;
    logic              w_run;
    logic [CNT_W-1:0]  w_count [CHANNELS];
    logic [CNT_W-1:0]  w_rd_mux;
    logic [CNT_W-1:0]  r_rd_count;

    // Warm-up lasts until every sync chain and prev register has seen real input.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_WARMUP;
            r_warm_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_warm_cnt <= w_warm_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_warm_cnt_nxt = r_warm_cnt;
        case (r_state)
            ST_WARMUP: begin
                if (r_warm_cnt == WARM_LAST) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_warm_cnt_nxt = r_warm_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_WARMUP;
            end
        endcase
    end

    assign w_run = (r_state == ST_RUN);
    assign ready = w_run;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        edge_counter_chan #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .i_clk       (clock),
            .i_rst_n     (reset_n),
            .i_sig       (sig_in[g]),
            .i_mask      (mask[g]),
            .i_mode      (edge_mode_t'(mode[2*g+1:2*g])),
            .i_run       (w_run),
            .i_sat_en    (sat_en),
            .i_threshold (threshold),
            .i_clr       (clr[g]),
            .o_count     (w_count[g]),
            .o_ovf       (ovf[g]),
            .o_hit       (hit[g])
        );
    end

    // Indices with no matching channel read back as zero.
    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                w_rd_mux = w_count[i];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_count <= '0;
        end else begin
            r_rd_count <= w_rd_mux;
        end
    end

    assign rd_count = r_rd_count;

endmodule

// File: tb/tb_edge_counter_bank.sv
// Directed bench for edge_counter_bank (4 channels, 4-bit counters, 2 sync stages).
module tb_edge_counter_bank;

    localparam int unsigned CHANNELS    = 4;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned SYNC_STAGES = 2;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b1;
    logic [3:0] sig_in;
    logic [3:0] mask;
    logic [7:0] mode;
    logic       sat_en;
    logic [3:0] threshold;
    logic [3:0] clr;
    logic [1:0] rd_idx;
    logic [3:0] rd_count;
    logic [3:0] ovf;
    logic [3:0] hit;
    logic       ready;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    edge_counter_bank #(
        .CHANNELS    (CHANNELS),
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .sig_in    (sig_in),
        .mask      (mask),
        .mode      (mode),
        .sat_en    (sat_en),
        .threshold (threshold),
        .clr       (clr),
        .rd_idx    (rd_idx),
        .rd_count  (rd_count),
        .ovf       (ovf),
        .hit       (hit),
        .ready     (ready)
    );

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic read_ch(input logic [1:0] idx, output logic [3:0] val);
        rd_idx = idx;
        cycles(1);
        val = rd_count;
    endtask

    task automatic test_reset();
        sig_in    = 4'hF;
        mask      = 4'hF;
        mode      = 8'hFF;
        sat_en    = 1'b0;
        threshold = 4'd0;
        clr       = 4'h0;
        rd_idx    = 2'd0;
        #2 reset_n = 1'b0;
        cycles(3);
        checks++;
        if (rd_count !== 4'd0) begin
            errors++; $display("FAIL reset_rd_count got %0d want 0", rd_count);
        end
        checks++;
        if (ovf !== 4'h0) begin
            errors++; $display("FAIL reset_ovf got %b want 0000", ovf);
        end
        checks++;
        if (hit !== 4'h0) begin
            errors++; $display("FAIL reset_hit got %b want 0000", hit);
        end
        checks++;
        if (ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready got %b want 0", ready);
        end
    endtask

    task automatic test_warmup(input string tag);
        logic [3:0] v;
        reset_n = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            cycles(1);
            checks++;
            if (ready !== (c == 3)) begin
                errors++;
                $display("FAIL %s_ready_cycle%0d got %b want %b", tag, c, ready, (c == 3));
            end
        end
        cycles(7);
        for (int ch = 0; ch < 4; ch++) begin
            read_ch(2'(ch), v);
            checks++;
            if (v !== 4'd0) begin
                errors++; $display("FAIL %s_count_ch%0d got %0d want 0", tag, ch, v);
            end
        end
    endtask

    task automatic test_rise();
        logic [3:0] v;
        mode = 8'h0D;  // ch0 rise, ch1 both, ch2/ch3 off
        for (int p = 0; p < 6; p++) begin
            sig_in = 4'h0;
            cycles(10);
            sig_in = 4'hF;
            if (p == 0) begin
                rd_idx = 2'd0;
                cycles(3);
                checks++;
                if (rd_count !== 4'd0) begin
                    errors++; $display("FAIL rise_latency_early got %0d want 0", rd_count);
                end
                cycles(1);
                checks++;
                if (rd_count !== 4'd1) begin
                    errors++; $display("FAIL rise_latency got %0d want 1", rd_count);
                end
                cycles(6);
            end else begin
                cycles(10);
            end
        end
        cycles(4);
        read_ch(2'd0, v);
        checks++;
        if (v !== 4'd6) begin errors++; $display("FAIL rise_ch0 got %0d want 6", v); end
        read_ch(2'd1, v);
        checks++;
        if (v !== 4'd12) begin errors++; $display("FAIL both_ch1 got %0d want 12", v); end
        read_ch(2'd2, v);
        checks++;
        if (v !== 4'd0) begin errors++; $display("FAIL off_ch2 got %0d want 0", v); end
        read_ch(2'd3, v);
        checks++;
        if (v !== 4'd0) begin errors++; $display("FAIL off_ch3 got %0d want 0", v); end
    endtask

    task automatic test_sat_wrap();
        logic [3:0] v;
        mode   = 8'h4D;  // ch3 now rise
        sat_en = 1'b1;
        for (int e = 0; e < 20; e++) begin
            sig_in[3] = 1'b0; cycles(2);
            sig_in[3] = 1'b1; cycles(2);
        end
        cycles(4);
        read_ch(2'd3, v);
        checks++;
        if (v !== 4'd15) begin errors++; $display("FAIL sat_count got %0d want 15", v); end
        checks++;
        if (ovf !== 4'b1000) begin errors++; $display("FAIL sat_ovf got %b want 1000", ovf); end
        checks++;
        if (hit !== 4'b0000) begin errors++; $display("FAIL sat_hit got %b want 0000", hit); end
        clr = 4'b1000;
        cycles(1);
        clr = 4'b0000;
        checks++;
        if (ovf !== 4'b0000) begin errors++; $display("FAIL clr_ovf got %b want 0000", ovf); end
        sat_en = 1'b0;
        for (int e = 0; e < 20; e++) begin
            sig_in[3] = 1'b0; cycles(2);
            sig_in[3] = 1'b1; cycles(2);
        end
        cycles(4);
        read_ch(2'd3, v);
        checks++;
        if (v !== 4'd4) begin errors++; $display("FAIL wrap_count got %0d want 4", v); end
        checks++;
        if (ovf !== 4'b1000) begin errors++; $display("FAIL wrap_ovf got %b want 1000", ovf); end
    endtask

    task automatic test_mask();
        logic [3:0] v;
        mode = 8'h5D;  // ch2 now rise
        mask = 4'b1011;
        for (int e = 0; e < 3; e++) begin
            sig_in[2] = 1'b0; cycles(2);
            sig_in[2] = 1'b1; cycles(2);
        end
        cycles(4);
        mask = 4'hF;
        cycles(5);
        read_ch(2'd2, v);
        checks++;
        if (v !== 4'd0) begin errors++; $display("FAIL mask_unmask got %0d want 0", v); end
        for (int e = 0; e < 2; e++) begin
            sig_in[2] = 1'b0; cycles(2);
            sig_in[2] = 1'b1; cycles(2);
        end
        cycles(4);
        read_ch(2'd2, v);
        checks++;
        if (v !== 4'd2) begin errors++; $display("FAIL mask_count got %0d want 2", v); end
    endtask

    task automatic test_threshold_clear();
        logic [3:0] v;
        logic [3:0] exp_hit;
        clr = 4'b0001;
        cycles(1);
        clr       = 4'b0000;
        threshold = 4'd3;
        for (int e = 1; e <= 5; e++) begin
            sig_in[0] = 1'b0; cycles(3);
            sig_in[0] = 1'b1; cycles(2);
            exp_hit = {3'b000, (e > 3)};
            checks++;
            if (hit !== exp_hit) begin
                errors++; $display("FAIL hit_pre_edge%0d got %b want %b", e, hit, exp_hit);
            end
            cycles(1);
            exp_hit = {3'b000, (e >= 3)};
            checks++;
            if (hit !== exp_hit) begin
                errors++; $display("FAIL hit_edge%0d got %b want %b", e, hit, exp_hit);
            end
            cycles(1);
        end
        cycles(2);
        read_ch(2'd0, v);
        checks++;
        if (v !== 4'd5) begin errors++; $display("FAIL thr_count got %0d want 5", v); end
        // Clear lands on the cycle the next rising edge is being detected.
        sig_in[0] = 1'b0; cycles(4);
        sig_in[0] = 1'b1; cycles(2);
        clr = 4'b0001;
        cycles(1);
        clr = 4'b0000;
        cycles(3);
        checks++;
        if (hit !== 4'b0000) begin errors++; $display("FAIL clr_edge_hit got %b want 0000", hit); end
        checks++;
        if (ovf !== 4'b1000) begin errors++; $display("FAIL clr_edge_ovf got %b want 1000", ovf); end
        read_ch(2'd0, v);
        checks++;
        if (v !== 4'd0) begin errors++; $display("FAIL clr_edge_count got %0d want 0", v); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] v;
        clr = 4'b0010;
        cycles(1);
        clr = 4'b0000;
        for (int e = 0; e < 6; e++) begin
            sig_in[1] = 1'b0; cycles(1);
            sig_in[1] = 1'b1; cycles(1);
        end
        cycles(4);
        read_ch(2'd1, v);
        checks++;
        if (v !== 4'd12) begin errors++; $display("FAIL b2b_count got %0d want 12", v); end
        checks++;
        if (ovf !== 4'b1000) begin errors++; $display("FAIL b2b_ovf got %b want 1000", ovf); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] v;
        threshold = 4'd2;
        read_ch(2'd1, v);
        checks++;
        if (v !== 4'd12) begin errors++; $display("FAIL pre_reset_ch1 got %0d want 12", v); end
        @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if (rd_count !== 4'd0) begin
            errors++; $display("FAIL mid_reset_rd_count got %0d want 0", rd_count);
        end
        checks++;
        if (ovf !== 4'h0) begin errors++; $display("FAIL mid_reset_ovf got %b want 0000", ovf); end
        checks++;
        if (hit !== 4'h0) begin errors++; $display("FAIL mid_reset_hit got %b want 0000", hit); end
        checks++;
        if (ready !== 1'b0) begin
            errors++; $display("FAIL mid_reset_ready got %b want 0", ready);
        end
        sig_in = 4'hF;
        mode   = 8'hFF;
        mask   = 4'hF;
        cycles(1);
        test_warmup("rewarm");
    endtask

    initial begin
        test_reset();
        test_warmup("warmup");
        test_rise();
        test_sat_wrap();
        test_mask();
        test_threshold_clear();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/edge_counter_bank.md
# edge_counter_bank

Parametrised multi-channel edge detector and event counter. Each of `CHANNELS` single-bit inputs is synchronised, edge-detected under a per-channel mode (rise, fall, both, off) and gated by a per-channel mask. Detected edges advance a per-channel counter with wrap or saturate behaviour, overflow and threshold-hit flags, and an indexed readout. It is the generalised successor to the single-vector posedge-counting check, used wherever the design counts events on several asynchronous strobes.

## Interface
- `CHANNELS`, 4: number of independent input channels (1..32).
- `CNT_W`, 8: counter width per channel (2..32).
- `SYNC_STAGES`, 2: synchroniser depth per input (1..4).
- `clock` input 1: sole clock, rising-edge active.
- `reset_n` input 1: reset; one clock, reset is asynchronous and active-low.
- `sig_in` input CHANNELS: asynchronous event inputs, one bit per channel.
- `mask` input CHANNELS: 1 = channel may count; 0 = edges ignored.
- `mode` input 2*CHANNELS: per-channel edge mode, channel i at bits [2i+1:2i].
- `sat_en` input 1: 1 = counters saturate at max; 0 = counters wrap.
- `threshold` input CNT_W: hit compare value, common to all channels; 0 disables hit.
- `clr` input CHANNELS: synchronous per-channel clear of count, ovf and hit.
- `rd_idx` input clog2(CHANNELS) (min 1): channel to read.
- `rd_count` output CNT_W: registered count of channel `rd_idx`.
- `ovf` output CHANNELS: sticky overflow flag per channel.
- `hit` output CHANNELS: sticky threshold-reached flag per channel.
- `ready` output 1: 1 once warm-up completes.

## Operation
- Mode encoding: 00 off, 01 rise, 10 fall, 11 both.
- Per channel:
  - The sync chain samples `sig_in[i]`.
  - `prev` holds the last synchronised value.
  - Edge = (rise and sync 0→1) or (fall and sync 1→0), ANDed with `mask[i]`.
- Masking gates detection only. The sync chain and `prev` always track the input, so unmasking never produces a spurious edge.
- Global state machine:
  - WARMUP is entered on reset; a counter runs `SYNC_STAGES+1` cycles, then the block moves to RUN.
  - RUN is held until the next reset.
  - In WARMUP, edges are suppressed and `ready` is 0.
- Counter update on an edge:
  - At `count` < max: `count`+1.
  - At max with `sat_en`=1: `count` holds max and `ovf` is set.
  - At max with `sat_en`=0: `count` goes to 0 and `ovf` is set.
- `hit[i]` sets on the cycle the updated count equals a nonzero `threshold`. It stays set afterwards, including after wrap.
- `clr[i]` has priority over a same-cycle edge. The result is count 0, `ovf` 0, `hit` 0, and that edge is lost.
- Changing `threshold` does not clear `hit`. It is compared only on counter updates.
- `rd_idx` out of range (≥ CHANNELS) returns 0.

## Timing
- Reset values:
  - sync chains, `prev` and counts: 0;
  - `ovf`, `hit`, `ready`: 0;
  - `rd_count`: 0.
- Edge-to-count latency: an input change meeting setup before rising edge k is reflected in the count after edge k+SYNC_STAGES.
- `ovf` and `hit` update on the same edge as the count.
- `rd_count` is registered from `rd_idx` and the current counts: one cycle of latency from a `rd_idx` change, and one further cycle after a count update.
- The minimum detectable input pulse is one clock period high and one low. Shorter pulses may be lost; this is not an error.
- Reset asserted mid-operation clears everything asynchronously. After release the block re-enters WARMUP, so a channel held high through reset does not count.

## Structure
- Package `edge_counter_pkg`:
  - `edge_mode_t` enum (`EDGE_OFF`, `EDGE_RISE`, `EDGE_FALL`, `EDGE_BOTH`);
  - `fsm_t` enum (`ST_WARMUP`, `ST_RUN`).
- Sub-module `edge_counter_chan`: sync chain, prev, detector, counter, ovf and hit for one channel. The top instantiates one per channel in a generate loop and holds the warm-up FSM, which drives a shared `run` enable, and the readout mux.

## Test plan
(`CHANNELS`=4, `CNT_W`=4, `SYNC_STAGES`=2.)
- **Warm-up:** release reset with `sig_in`=4'hF, all `mask`=1, mode both, hold 10 cycles -> all counts 0, `ready`=1 from cycle 3.
- **Rise count:** ch0 mode rise, 6 full periods of 20 cycles -> ch0 count 6, other channels 0, `rd_idx`=0 gives `rd_count`=6 one cycle later. Ch1 in mode both over the same 6 periods -> 12.
- **Saturate vs wrap:** 20 rising edges with `sat_en`=1 -> count 15, `ovf`=1. Repeat after `clr` with `sat_en`=0 -> count 4, `ovf`=1.
- **Mask:** 3 edges with `mask[2]`=0, then set `mask[2]`=1 while the input is high -> no count. Then 2 more rising edges -> count 2.
- **Threshold/clear:** `threshold`=3, 5 edges -> `hit` sets on the 3rd edge's update and stays 1. Then `clr` in the same cycle as a detected edge -> count 0, `hit` 0, `ovf` 0.
- **Reset mid-run:** assert `reset_n`=0 asynchronously mid-cycle with counts nonzero -> all outputs 0 immediately, and WARMUP repeats after release.
